// File: rtl/trap_arbiter.sv
// trap_arbiter: machine-mode trap entry and mret sequencer beside ROB commit.
// Optional TRAP_VECTORED_EN: vectored mtvec targets for interrupts when mtvec[1:0]==2'b01.
`ifndef XDEF
`define XDEF 64
`endif

package trap_arbiter_pkg;
    typedef struct packed {
        logic [`XDEF-1:0] cause;
        logic [`XDEF-1:0] epc;
        logic [`XDEF-1:0] tval;
    } trapInfo_t;
endpackage

// state    | meaning
// IDLE     | commit runs freely; exceptions, mret and interrupts sampled
// BLOCK    | interrupt pending; commit blocked, waiting for commit to drain
// UPDATE   | one-cycle CSR update strobe; redirect target registered
// REDIRECT | redirect held until the frontend accepts it, then squash
module trap_arbiter
    import trap_arbiter_pkg::*;
#(
    parameter int unsigned XLEN     = `XDEF,
    parameter logic [15:0] IRQ_MASK = 16'h0AAA
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_exc_vld,
    input  trapInfo_t       i_exc_info,
    input  logic            i_mret_vld,
    input  logic [XLEN-1:0] i_mepc,
    input  logic [XLEN-1:0] i_mtvec,
    input  logic [15:0]     i_mip,
    input  logic [15:0]     i_mie,
    input  logic            i_mstatus_mie,
    input  logic [XLEN-1:0] i_commit_pc,
    input  logic            i_commit_idle,
    output logic            o_commit_block,
    output logic            o_csr_wr_vld,
    output trapInfo_t       o_csr_trap,
    output logic            o_csr_is_irq,
    output logic            o_csr_mret,
    output logic            o_redirect_vld,
    output logic [XLEN-1:0] o_redirect_pc,
    input  logic            i_redirect_rdy,
    output logic            o_squash
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_BLOCK    = 2'd1,
        S_UPDATE   = 2'd2,
        S_REDIRECT = 2'd3
    } state_t;

    state_t          state_q, state_d;
    trapInfo_t       trap_q, trap_d;
    logic            is_irq_q, is_irq_d;
    logic            mret_q, mret_d;
    logic [XLEN-1:0] target_q, target_d;

    logic [15:0]     irq_pend;
    logic            irq_taken;
    logic [3:0]      irq_cause;
    logic [XLEN-1:0] trap_base;
    logic [XLEN-1:0] trap_target;

    assign irq_pend  = i_mip & i_mie & IRQ_MASK;
    assign irq_taken = i_mstatus_mie && (|irq_pend);

    // Fixed priority: mExter > mSoft > mTimer > sExter > sSoft > sTimer.
    always_comb begin
        irq_cause = 4'd0;
        if (irq_pend[11])     irq_cause = 4'd11;
        else if (irq_pend[3]) irq_cause = 4'd3;
        else if (irq_pend[7]) irq_cause = 4'd7;
        else if (irq_pend[9]) irq_cause = 4'd9;
        else if (irq_pend[1]) irq_cause = 4'd1;
        else if (irq_pend[5]) irq_cause = 4'd5;
    end

    assign trap_base = i_mtvec & ~XLEN'(3);

`ifdef TRAP_VECTORED_EN
    always_comb begin
        trap_target = trap_base;
        if (is_irq_q && (i_mtvec[1:0] == 2'b01)) begin
            trap_target = trap_base + (trap_q.cause << 2);
        end
    end
`else
    assign trap_target = trap_base;
`endif

    always_comb begin
        state_d        = state_q;
        trap_d         = trap_q;
        is_irq_d       = is_irq_q;
        mret_d         = mret_q;
        target_d       = target_q;
        o_commit_block = 1'b0;
        o_csr_wr_vld   = 1'b0;
        o_csr_trap     = '0;
        o_csr_is_irq   = 1'b0;
        o_csr_mret     = 1'b0;
        o_redirect_vld = 1'b0;
        o_redirect_pc  = '0;
        o_squash       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (i_exc_vld) begin
                    trap_d   = i_exc_info;
                    is_irq_d = 1'b0;
                    mret_d   = 1'b0;
                    state_d  = S_UPDATE;
                end else if (i_mret_vld) begin
                    trap_d   = '0;
                    is_irq_d = 1'b0;
                    mret_d   = 1'b1;
                    target_d = i_mepc;
                    state_d  = S_UPDATE;
                end else if (irq_taken) begin
                    trap_d       = '0;
                    trap_d.cause = XLEN'(irq_cause);
                    is_irq_d     = 1'b1;
                    mret_d       = 1'b0;
                    state_d      = S_BLOCK;
                end
            end

            S_BLOCK: begin
                o_commit_block = 1'b1;
                // An instruction already past the registered block may still trap.
                if (i_exc_vld) begin
                    trap_d   = i_exc_info;
                    is_irq_d = 1'b0;
                    state_d  = S_UPDATE;
                end else if (i_commit_idle) begin
                    trap_d.epc  = i_commit_pc;
                    trap_d.tval = '0;
                    state_d     = S_UPDATE;
                end else if (!irq_taken) begin
                    state_d = S_IDLE;
                end
            end

            S_UPDATE: begin
                o_commit_block = 1'b1;
                o_csr_wr_vld   = 1'b1;
                o_csr_trap     = trap_q;
                o_csr_is_irq   = is_irq_q;
                o_csr_mret     = mret_q;
                if (!mret_q) begin
                    target_d = trap_target;
                end
                state_d = S_REDIRECT;
            end

            S_REDIRECT: begin
                o_commit_block = 1'b1;
                o_redirect_vld = 1'b1;
                o_redirect_pc  = target_q;
                if (i_redirect_rdy) begin
                    o_squash = 1'b1;
                    state_d  = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            trap_q   <= '0;
            is_irq_q <= 1'b0;
            mret_q   <= 1'b0;
            target_q <= '0;
        end else begin
            state_q  <= state_d;
            trap_q   <= trap_d;
            is_irq_q <= is_irq_d;
            mret_q   <= mret_d;
            target_q <= target_d;
        end
    end

endmodule

// File: tb/tb_trap_arbiter.sv
// tb_trap_arbiter: randomized scenarios for trap_arbiter checked against a transaction-level model.
// Expected targets follow TRAP_VECTORED_EN the same way the design build does.
module tb_trap_arbiter;
    import trap_arbiter_pkg::*;

    logic        clk;
    logic        rst;
    logic        i_exc_vld;
    trapInfo_t   i_exc_info;
    logic        i_mret_vld;
    logic [63:0] i_mepc;
    logic [63:0] i_mtvec;
    logic [15:0] i_mip;
    logic [15:0] i_mie;
    logic        i_mstatus_mie;
    logic [63:0] i_commit_pc;
    logic        i_commit_idle;
    logic        o_commit_block;
    logic        o_csr_wr_vld;
    trapInfo_t   o_csr_trap;
    logic        o_csr_is_irq;
    logic        o_csr_mret;
    logic        o_redirect_vld;
    logic [63:0] o_redirect_pc;
    logic        i_redirect_rdy;
    logic        o_squash;

    int checks = 0;
    int errors = 0;

    trap_arbiter dut (
        .clk            (clk),
        .rst            (rst),
        .i_exc_vld      (i_exc_vld),
        .i_exc_info     (i_exc_info),
        .i_mret_vld     (i_mret_vld),
        .i_mepc         (i_mepc),
        .i_mtvec        (i_mtvec),
        .i_mip          (i_mip),
        .i_mie          (i_mie),
        .i_mstatus_mie  (i_mstatus_mie),
        .i_commit_pc    (i_commit_pc),
        .i_commit_idle  (i_commit_idle),
        .o_commit_block (o_commit_block),
        .o_csr_wr_vld   (o_csr_wr_vld),
        .o_csr_trap     (o_csr_trap),
        .o_csr_is_irq   (o_csr_is_irq),
        .o_csr_mret     (o_csr_mret),
        .o_redirect_vld (o_redirect_vld),
        .o_redirect_pc  (o_redirect_pc),
        .i_redirect_rdy (i_redirect_rdy),
        .o_squash       (o_squash)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference rules: interrupt priority and trap/mret target arithmetic.
    function automatic int exp_cause(input logic [15:0] mip, input logic [15:0] mie);
        int order[6];
        logic [15:0] pend;
        order = '{11, 3, 7, 9, 1, 5};
        pend  = mip & mie & 16'h0AAA;
        foreach (order[i]) if (pend[order[i]]) return order[i];
        return -1;
    endfunction

    function automatic logic [63:0] exp_target(input logic [63:0] mtvec, input bit irq,
                                               input logic [63:0] cause);
        logic [63:0] base;
        base = mtvec - (mtvec % 4);
`ifdef TRAP_VECTORED_EN
        if (irq && (mtvec % 4) == 1) return base + cause * 4;
`endif
        return base;
    endfunction

    function automatic trapInfo_t rand_info();
        trapInfo_t t;
        t.cause = 64'($urandom_range(0, 15));
        t.epc   = {$urandom, $urandom};
        t.tval  = {$urandom, $urandom};
        return t;
    endfunction

    task automatic clear_inputs();
        i_exc_vld      = 1'b0;
        i_exc_info     = '0;
        i_mret_vld     = 1'b0;
        i_mepc         = '0;
        i_mtvec        = '0;
        i_mip          = '0;
        i_mie          = '0;
        i_mstatus_mie  = 1'b0;
        i_commit_pc    = '0;
        i_commit_idle  = 1'b0;
        i_redirect_rdy = 1'b0;
    endtask

    // Entered one step after the UPDATE cycle; leaves one step after the first IDLE cycle.
    task automatic do_redirect(input logic [63:0] exp_pc, input int delay, input string tag);
        for (int i = 0; i < delay; i++) begin
            i_redirect_rdy = 1'b0;
            i_exc_vld      = 1'($urandom_range(0, 1));
            i_mret_vld     = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk({tag, "_hold_vld"}, o_redirect_vld, 1);
            chk({tag, "_hold_pc"}, o_redirect_pc, exp_pc);
            chk({tag, "_hold_squash"}, o_squash, 0);
            chk({tag, "_hold_wr"}, o_csr_wr_vld, 0);
            chk({tag, "_hold_block"}, o_commit_block, 1);
            step();
        end
        i_exc_vld      = 1'b0;
        i_mret_vld     = 1'b0;
        i_redirect_rdy = 1'b1;
        @(negedge clk);
        chk({tag, "_rd_vld"}, o_redirect_vld, 1);
        chk({tag, "_rd_pc"}, o_redirect_pc, exp_pc);
        chk({tag, "_squash"}, o_squash, 1);
        chk({tag, "_rd_block"}, o_commit_block, 1);
        step();
        i_redirect_rdy = 1'b0;
        @(negedge clk);
        chk({tag, "_idle_block"}, o_commit_block, 0);
        chk({tag, "_idle_squash"}, o_squash, 0);
        chk({tag, "_idle_vld"}, o_redirect_vld, 0);
        step();
    endtask

    task automatic run_exc(input trapInfo_t info, input logic [63:0] mtvec, input int delay,
                           input string tag);
        i_mtvec    = mtvec;
        i_exc_info = info;
        i_exc_vld  = 1'b1;
        i_mret_vld = 1'($urandom_range(0, 1));
        i_mepc     = {$urandom, $urandom};
        @(negedge clk);
        chk({tag, "_n_block"}, o_commit_block, 0);
        chk({tag, "_n_wr"}, o_csr_wr_vld, 0);
        step();
        i_exc_vld  = 1'($urandom_range(0, 1));
        i_exc_info = rand_info();
        i_mret_vld = 1'b0;
        @(negedge clk);
        chk({tag, "_wr"}, o_csr_wr_vld, 1);
        chk({tag, "_cause"}, o_csr_trap.cause, info.cause);
        chk({tag, "_epc"}, o_csr_trap.epc, info.epc);
        chk({tag, "_tval"}, o_csr_trap.tval, info.tval);
        chk({tag, "_is_irq"}, o_csr_is_irq, 0);
        chk({tag, "_mret"}, o_csr_mret, 0);
        chk({tag, "_upd_block"}, o_commit_block, 1);
        chk({tag, "_upd_vld"}, o_redirect_vld, 0);
        step();
        do_redirect(exp_target(mtvec, 1'b0, info.cause), delay, tag);
    endtask

    task automatic run_mret(input logic [63:0] mepc, input int delay, input string tag);
        i_mtvec    = {$urandom, $urandom};
        i_mepc     = mepc;
        i_mret_vld = 1'b1;
        @(negedge clk);
        chk({tag, "_n_block"}, o_commit_block, 0);
        step();
        i_mret_vld = 1'b0;
        i_mepc     = ~mepc;
        @(negedge clk);
        chk({tag, "_wr"}, o_csr_wr_vld, 1);
        chk({tag, "_mret"}, o_csr_mret, 1);
        chk({tag, "_is_irq"}, o_csr_is_irq, 0);
        step();
        do_redirect(mepc, delay, tag);
    endtask

    // mode 0: normal drain, 1: abort by disabling, 2: exception overtakes in BLOCK.
    task automatic run_irq(input logic [15:0] mip, input logic [15:0] mie, input logic [63:0] mtvec,
                           input int wait_cyc, input int mode, input int delay, input string tag);
        int          cause;
        logic [63:0] pc;
        trapInfo_t   info;
        cause         = exp_cause(mip, mie);
        i_mtvec       = mtvec;
        i_mip         = mip;
        i_mie         = mie;
        i_mstatus_mie = 1'b1;
        i_commit_idle = 1'b0;
        @(negedge clk);
        chk({tag, "_n_block"}, o_commit_block, 0);
        step();
        for (int i = 0; i < wait_cyc; i++) begin
            @(negedge clk);
            chk({tag, "_blk_block"}, o_commit_block, 1);
            chk({tag, "_blk_wr"}, o_csr_wr_vld, 0);
            step();
        end
        if (mode == 1) begin
            if ($urandom_range(0, 1) == 0) i_mie = '0;
            else i_mstatus_mie = 1'b0;
            @(negedge clk);
            chk({tag, "_ab_block"}, o_commit_block, 1);
            step();
            @(negedge clk);
            chk({tag, "_ab_drop"}, o_commit_block, 0);
            chk({tag, "_ab_wr"}, o_csr_wr_vld, 0);
            chk({tag, "_ab_vld"}, o_redirect_vld, 0);
            i_mip         = '0;
            i_mie         = '0;
            i_mstatus_mie = 1'b0;
            step();
        end else if (mode == 2) begin
            info       = rand_info();
            i_exc_info = info;
            i_exc_vld  = 1'b1;
            @(negedge clk);
            chk({tag, "_ex_block"}, o_commit_block, 1);
            step();
            i_exc_vld = 1'b0;
            i_mie     = '0;
            @(negedge clk);
            chk({tag, "_ex_wr"}, o_csr_wr_vld, 1);
            chk({tag, "_ex_cause"}, o_csr_trap.cause, info.cause);
            chk({tag, "_ex_epc"}, o_csr_trap.epc, info.epc);
            chk({tag, "_ex_is_irq"}, o_csr_is_irq, 0);
            step();
            do_redirect(exp_target(mtvec, 1'b0, info.cause), delay, tag);
        end else begin
            pc            = {$urandom, $urandom};
            i_commit_idle = 1'b1;
            i_commit_pc   = pc;
            @(negedge clk);
            chk({tag, "_dr_block"}, o_commit_block, 1);
            chk({tag, "_dr_wr"}, o_csr_wr_vld, 0);
            step();
            i_commit_idle = 1'b0;
            i_commit_pc   = ~pc;
            i_mie         = '0;
            @(negedge clk);
            chk({tag, "_wr"}, o_csr_wr_vld, 1);
            chk({tag, "_cause"}, o_csr_trap.cause, 64'(cause));
            chk({tag, "_is_irq"}, o_csr_is_irq, 1);
            chk({tag, "_epc"}, o_csr_trap.epc, pc);
            chk({tag, "_tval"}, o_csr_trap.tval, 0);
            chk({tag, "_mret"}, o_csr_mret, 0);
            step();
            do_redirect(exp_target(mtvec, 1'b1, 64'(cause)), delay, tag);
        end
        i_mip         = '0;
        i_mstatus_mie = 1'b0;
    endtask

    initial begin
        trapInfo_t   info;
        logic [63:0] mtvec;
        logic [63:0] pc;
        logic [15:0] mip;
        logic [15:0] mie;
        int          k;
        int          kind;

        clear_inputs();
        rst = 1'b0;
        i_redirect_rdy = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_block", o_commit_block, 0);
        chk("rst_wr", o_csr_wr_vld, 0);
        chk("rst_trap", o_csr_trap.epc | o_csr_trap.cause | o_csr_trap.tval, 0);
        chk("rst_vld", o_redirect_vld, 0);
        chk("rst_pc", o_redirect_pc, 0);
        chk("rst_squash", o_squash, 0);
        i_redirect_rdy = 1'b0;
        rst = 1'b1;
        step();

        info.cause = 64'd2;
        info.epc   = 64'h8000_0010;
        info.tval  = 64'h13;
        run_exc(info, 64'h8000_0100, 0, "dir_exc");
        chk("dir_exc_base", exp_target(64'h8000_0100, 1'b0, 64'd2), 64'h8000_0100);

        run_irq(16'h0880, 16'h0880, 64'h8000_0200, 3, 0, 1, "dir_irq");
        run_irq(16'h0080, 16'h0080, 64'h8000_0101, 1, 0, 0, "dir_vec");
        run_irq(16'h0222, 16'h0FFF, 64'h8000_0400, 2, 1, 0, "dir_abort");
        run_exc(rand_info(), {$urandom, $urandom}, 5, "dir_hold");

        // Same-cycle exception, mret and interrupt: exception first, interrupt afterwards.
        info          = rand_info();
        mtvec         = 64'h8000_0101;
        i_mtvec       = mtvec;
        i_exc_info    = info;
        i_exc_vld     = 1'b1;
        i_mret_vld    = 1'b1;
        i_mepc        = {$urandom, $urandom};
        i_mip         = 16'h0080;
        i_mie         = 16'h0080;
        i_mstatus_mie = 1'b1;
        @(negedge clk);
        chk("prio_n_block", o_commit_block, 0);
        step();
        i_exc_vld  = 1'b0;
        i_mret_vld = 1'b0;
        @(negedge clk);
        chk("prio_wr", o_csr_wr_vld, 1);
        chk("prio_cause", o_csr_trap.cause, info.cause);
        chk("prio_is_irq", o_csr_is_irq, 0);
        chk("prio_mret", o_csr_mret, 0);
        step();
        do_redirect(exp_target(mtvec, 1'b0, info.cause), 1, "prio");
        pc            = {$urandom, $urandom};
        i_commit_idle = 1'b1;
        i_commit_pc   = pc;
        @(negedge clk);
        chk("prio_irq_block", o_commit_block, 1);
        chk("prio_irq_wr0", o_csr_wr_vld, 0);
        step();
        i_commit_idle = 1'b0;
        i_mie         = '0;
        @(negedge clk);
        chk("prio_irq_wr", o_csr_wr_vld, 1);
        chk("prio_irq_cause", o_csr_trap.cause, 64'd7);
        chk("prio_irq_is_irq", o_csr_is_irq, 1);
        chk("prio_irq_epc", o_csr_trap.epc, pc);
        step();
        do_redirect(exp_target(mtvec, 1'b1, 64'd7), 0, "prio_irq");
        i_mip         = '0;
        i_mstatus_mie = 1'b0;

        // Asynchronous reset while a redirect is outstanding.
        i_mtvec    = 64'h8000_0300;
        i_exc_info = rand_info();
        i_exc_vld  = 1'b1;
        step();
        i_exc_vld = 1'b0;
        step();
        @(negedge clk);
        chk("rr_vld_before", o_redirect_vld, 1);
        #2;
        rst = 1'b0;
        #1;
        chk("rr_block", o_commit_block, 0);
        chk("rr_vld", o_redirect_vld, 0);
        chk("rr_pc", o_redirect_pc, 0);
        chk("rr_wr", o_csr_wr_vld, 0);
        chk("rr_squash", o_squash, 0);
        @(negedge clk);
        rst = 1'b1;
        step();
        @(negedge clk);
        chk("rr_idle_block", o_commit_block, 0);
        step();
        run_mret({$urandom, $urandom}, 2, "dir_mret");

        for (int n = 0; n < 40; n++) begin
            kind = int'($urandom_range(0, 4));
            k    = 1 + 2 * int'($urandom_range(0, 5));
            mip  = 16'($urandom);
            mie  = 16'($urandom);
            mip[k] = 1'b1;
            mie[k] = 1'b1;
            case (kind)
                0: run_exc(rand_info(), {$urandom, $urandom}, int'($urandom_range(0, 4)), "r_exc");
                1: run_mret({$urandom, $urandom}, int'($urandom_range(0, 4)), "r_mret");
                default: run_irq(mip, mie, {$urandom, $urandom}, int'($urandom_range(0, 4)),
                                 kind - 2, int'($urandom_range(0, 4)), "r_irq");
            endcase
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
